// File: rtl/dec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dec_pkg
//  Description : Shared mode encodings, FSM state type and clog2 helper for
//                the decoder_scanner block.
//  Revision    : 1.0 - initial release
// ============================================================================
package dec_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    // Ceiling log2, usable in constant expressions (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_decoder
//  Description : Combinational N-to-2^N one-hot decoder with enable.
//                All outputs are zero when en is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_decoder #(
    parameter int N = 4
) (
    input  logic [N-1:0]      in,
    input  logic              en,
    output logic [2**N-1:0]   y
);

    // Drive exactly one line high for the selected index when enabled.
    always_comb begin
        y = '0;
        if (en) begin
            y[in] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decoder_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_scanner
//  Description : Registered one-hot decoder. Direct mode holds a latched
//                address; scan mode walks the active line across an
//                inclusive [lo, hi] window, DWELL cycles per line, with a
//                one-cycle wrap pulse when the walk returns to lo.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_scanner
    import dec_pkg::*;
#(
    parameter int N     = 4,
    parameter int DWELL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic               load,
    input  logic               stop,
    input  logic [N-1:0]       addr,
    input  logic [N-1:0]       scan_lo,
    input  logic [N-1:0]       scan_hi,
    output logic [2**N-1:0]    y,
    output logic [N-1:0]       idx,
    output logic               wrap,
    output logic               busy
);

    // Dwell counter is at least one bit wide so DWELL=1 still has a counter.
    localparam int              DCW         = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);
    localparam logic [DCW-1:0]  c_dcnt_last = DCW'(DWELL - 1);

    state_t          r_state, w_state_nx;
    logic [N-1:0]    r_idx,   w_idx_nx;
    logic [N-1:0]    r_lo,    w_lo_nx;
    logic [N-1:0]    r_hi,    w_hi_nx;
    logic [DCW-1:0]  r_dcnt,  w_dcnt_nx;
    logic            r_wrap,  w_wrap_nx;
    logic            r_busy;
    logic            w_y_en;

    // Next-state and datapath decisions; priority is stop, then load, then scan advance.
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_lo_nx    = r_lo;
        w_hi_nx    = r_hi;
        w_dcnt_nx  = r_dcnt;
        w_wrap_nx  = 1'b0;

        if (stop) begin
            w_state_nx = ST_IDLE;
        end else if (load) begin
            w_dcnt_nx = '0;
            if (mode == MODE_DIRECT) begin
                w_idx_nx   = addr;
                w_state_nx = ST_HOLD;
            end else begin
                w_idx_nx   = scan_lo;
                w_lo_nx    = scan_lo;
                // An inverted window collapses to the single line scan_lo.
                w_hi_nx    = (scan_hi < scan_lo) ? scan_lo : scan_hi;
                w_state_nx = ST_SCAN;
            end
        end else if ((r_state == ST_SCAN) && en) begin
            if (r_dcnt == c_dcnt_last) begin
                w_dcnt_nx = '0;
                // Wrap is decided by comparison with hi, never by counter overflow.
                if (r_idx != r_hi) begin
                    w_idx_nx = r_idx + 1'b1;
                end else begin
                    w_idx_nx  = r_lo;
                    w_wrap_nx = 1'b1;
                end
            end else begin
                w_dcnt_nx = r_dcnt + 1'b1;
            end
        end
    end

    // State, index, window, dwell and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_dcnt  <= '0;
            r_wrap  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_lo    <= w_lo_nx;
            r_hi    <= w_hi_nx;
            r_dcnt  <= w_dcnt_nx;
            r_wrap  <= w_wrap_nx;
            r_busy  <= (w_state_nx != ST_IDLE);
        end
    end

    assign w_y_en = en && (r_state != ST_IDLE);

    onehot_decoder #(
        .N (N)
    ) u_onehot_decoder (
        .in (r_idx),
        .en (w_y_en),
        .y  (y)
    );

    assign idx  = r_idx;
    assign wrap = r_wrap;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_scanner
//  Description : Self-checking bench for decoder_scanner (N=4, DWELL=2)
//                against a cycle-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_scanner;

    localparam int N     = 4;
    localparam int DWELL = 2;
    localparam int W     = 1 << N;

    logic          clk = 1'b0;
    logic          rst, en, mode, load, stop;
    logic [N-1:0]  addr, scan_lo, scan_hi;
    logic [W-1:0]  y;
    logic [N-1:0]  idx;
    logic          wrap, busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: active flag, scanning flag, line index, window, cycles spent on line.
    bit m_active, m_scanning, m_wrap;
    int m_idx, m_lo, m_hi, m_age;

    int exp_seq[8]  = '{3, 3, 4, 4, 5, 5, 3, 3};
    int exp_wrap[8] = '{0, 0, 0, 0, 0, 0, 1, 0};

    decoder_scanner #(
        .N     (N),
        .DWELL (DWELL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .load    (load),
        .stop    (stop),
        .addr    (addr),
        .scan_lo (scan_lo),
        .scan_hi (scan_hi),
        .y       (y),
        .idx     (idx),
        .wrap    (wrap),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply the inputs present at this edge to the model.
    task automatic model_update();
        m_wrap = 1'b0;
        if (rst) begin
            m_active   = 1'b0;
            m_scanning = 1'b0;
            m_idx      = 0;
            m_age      = 0;
        end else if (stop) begin
            m_active   = 1'b0;
            m_scanning = 1'b0;
        end else if (load) begin
            m_active   = 1'b1;
            m_scanning = mode;
            m_age      = 0;
            if (!mode) begin
                m_idx = int'(addr);
            end else begin
                m_lo  = int'(scan_lo);
                m_hi  = (scan_hi < scan_lo) ? int'(scan_lo) : int'(scan_hi);
                m_idx = m_lo;
            end
        end else if (m_scanning && en) begin
            m_age++;
            if (m_age == DWELL) begin
                m_age = 0;
                if (m_idx == m_hi) begin
                    m_idx  = m_lo;
                    m_wrap = 1'b1;
                end else begin
                    m_idx++;
                end
            end
        end
    endtask

    // One clock: edge, model update, then compare all outputs off the edge.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_eq("y",    32'(y),    (en && m_active) ? (32'd1 << m_idx) : 32'd0);
        check_eq("idx",  32'(idx),  32'(m_idx));
        check_eq("wrap", 32'(wrap), 32'(m_wrap));
        check_eq("busy", 32'(busy), 32'(m_active));
    endtask

    task automatic idle_cycles(input int n);
        load = 1'b0;
        stop = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_load(input bit md, input int a, input int lo, input int hi);
        load    = 1'b1;
        stop    = 1'b0;
        mode    = md;
        addr    = N'(a);
        scan_lo = N'(lo);
        scan_hi = N'(hi);
        step();
        load    = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        load = 1'b0;
        step();
        stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b0; load = 1'b0; stop = 1'b0;
        addr = '0; scan_lo = '0; scan_hi = '0;

        // Reset held three cycles, then released with no command.
        repeat (3) step();
        check_eq("rst_y", 32'(y), 32'd0);
        rst = 1'b0;
        idle_cycles(2);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Direct mode hold with enable masking.
        do_load(1'b0, 9, 0, 0);
        check_eq("direct_y", 32'(y), 32'h0200);
        en = 1'b0;
        idle_cycles(1);
        check_eq("direct_masked_y", 32'(y), 32'd0);
        check_eq("direct_masked_idx", 32'(idx), 32'd9);
        en = 1'b1;
        idle_cycles(1);
        check_eq("direct_unmasked_y", 32'(y), 32'h0200);
        do_stop();
        check_eq("stop_busy", 32'(busy), 32'd0);

        // Scan window 3..5 sequence and wrap position.
        do_load(1'b1, 0, 3, 5);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) idle_cycles(1);
            check_eq("scan_seq", 32'(idx), 32'(exp_seq[i]));
            check_eq("scan_wrap", 32'(wrap), 32'(exp_wrap[i]));
        end
        // Pause mid-line and resume.
        en = 1'b0;
        idle_cycles(3);
        en = 1'b1;
        idle_cycles(5);

        // Top-of-range window: no overflow past 15.
        do_load(1'b1, 0, 14, 15);
        idle_cycles(6);
        // Inverted window collapses to line 7.
        do_load(1'b1, 0, 7, 2);
        check_eq("inv_window_y", 32'(y), 32'h0080);
        idle_cycles(6);
        check_eq("inv_window_y_late", 32'(y), 32'h0080);

        // Stop and load together: stop wins.
        load = 1'b1; stop = 1'b1; mode = 1'b1;
        step();
        load = 1'b0; stop = 1'b0;
        check_eq("stop_load_busy", 32'(busy), 32'd0);

        // Direct load during scan.
        do_load(1'b1, 0, 3, 5);
        idle_cycles(1);
        do_load(1'b0, 1, 0, 0);
        check_eq("redirect_y", 32'(y), 32'h0002);
        idle_cycles(3);

        // Reset mid-scan at idx 4, scan must not resume.
        do_load(1'b1, 0, 3, 5);
        for (int i = 0; i < 8 && idx != 4'd4; i++) idle_cycles(1);
        check_eq("reach_idx4", 32'(idx), 32'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midscan_rst_y", 32'(y), 32'd0);
        check_eq("midscan_rst_idx", 32'(idx), 32'd0);
        idle_cycles(3);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 99) == 0);
            stop    = ($urandom_range(0, 19) == 0);
            load    = ($urandom_range(0, 7) == 0);
            en      = ($urandom_range(0, 99) < 85);
            mode    = 1'($urandom);
            addr    = N'($urandom);
            scan_lo = N'($urandom);
            scan_hi = N'($urandom);
            step();
        end
        rst = 1'b0; load = 1'b0; stop = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
